// File: rtl/yarvi_alu_issue.sv
// Operand-issue register stage in front of the combinational yarvi_alu: selects and
// forwards operands, canonicalises insn30 and holds the issued op until writeback accepts it.
module yarvi_alu_issue #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [1:0]      in_op1_sel,
    input  logic            in_use_imm,
    input  logic [2:0]      in_funct3,
    input  logic            in_insn30,
    input  logic [4:0]      in_rd,
    input  logic            in_wben,
    input  logic [XLEN-1:0] alu_result,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            alu_insn30,
    output logic [2:0]      alu_funct3,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    output logic [4:0]      out_rd,
    output logic            out_wben
);

    typedef enum logic [2:0] {
        F_ADDSUB = 3'd0,
        F_SLL    = 3'd1,
        F_SLT    = 3'd2,
        F_SLTU   = 3'd3,
        F_XOR    = 3'd4,
        F_SR     = 3'd5,
        F_OR     = 3'd6,
        F_AND    = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2,
        OP1_RSVD = 2'd3
    } op1_sel_e;

    logic            accept;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] op1_next;
    logic [XLEN-1:0] op2_next;
    logic            insn30_next;

    // The held instruction is younger than the one in writeback, so its result wins.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_val,
        input logic            held_wr,
        input logic [4:0]      held_rd,
        input logic [XLEN-1:0] held_val,
        input logic            wb_wr,
        input logic [4:0]      wb_idx,
        input logic [XLEN-1:0] wb_data
    );
        if (idx == 5'd0)
            return '0;
        if (FWD_EN && held_wr && held_rd == idx)
            return held_val;
        if (FWD_EN && wb_wr && wb_idx == idx)
            return wb_data;
        return rf_val;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        rs1_fwd = fwd(in_rs1, in_rs1_val, out_valid && out_wben, out_rd, alu_result,
                      wb_valid, wb_rd, wb_val);
        rs2_fwd = fwd(in_rs2, in_rs2_val, out_valid && out_wben, out_rd, alu_result,
                      wb_valid, wb_rd, wb_val);

        op1_next = '0;
        case (op1_sel_e'(in_op1_sel))
            OP1_RS1: op1_next = rs1_fwd;
            OP1_PC:  op1_next = in_pc;
            default: op1_next = '0;
        endcase

        op2_next = in_use_imm ? in_imm : rs2_fwd;

        // Bit 30 of an I-type is immediate data except for SRAI; only honour it where it selects SUB/SRA.
        insn30_next = 1'b0;
        if (in_funct3 == F_SR || (in_funct3 == F_ADDSUB && !in_use_imm))
            insn30_next = in_insn30;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            alu_insn30 <= 1'b0;
            alu_funct3 <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            out_rd     <= '0;
            out_wben   <= 1'b0;
        end else begin
            out_valid <= !flush && (accept || (out_valid && !out_ready));
            if (accept) begin
                alu_insn30 <= insn30_next;
                alu_funct3 <= in_funct3;
                alu_op1    <= op1_next;
                alu_op2    <= op2_next;
                out_rd     <= in_rd;
                out_wben   <= in_wben && (in_rd != 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_yarvi_alu_issue.sv
// Bench for yarvi_alu_issue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the issue register.
module tb_yarvi_alu_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_rs1_val = '0;
    logic [31:0] in_rs2_val = '0;
    logic [31:0] in_imm = '0;
    logic [1:0]  in_op1_sel = '0;
    logic        in_use_imm = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic        in_insn30 = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_wben = 1'b0;
    logic [31:0] alu_result = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_val = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        alu_insn30;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  out_rd;
    logic        out_wben;

    int checks = 0;
    int failures = 0;

    yarvi_alu_issue #(.XLEN(32), .FWD_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .in_imm(in_imm), .in_op1_sel(in_op1_sel), .in_use_imm(in_use_imm),
        .in_funct3(in_funct3), .in_insn30(in_insn30), .in_rd(in_rd), .in_wben(in_wben),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_val(wb_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_insn30(alu_insn30), .alu_funct3(alu_funct3), .alu_op1(alu_op1),
        .alu_op2(alu_op2), .out_rd(out_rd), .out_wben(out_wben)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Transaction model: the instruction held in the issue register.
    logic        m_started = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_insn30 = 1'b0;
    logic [2:0]  m_funct3 = '0;
    logic [31:0] m_op1 = '0;
    logic [31:0] m_op2 = '0;
    logic [4:0]  m_rd = '0;
    logic        m_wben = 1'b0;

    function automatic logic [31:0] source_value(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (m_valid && m_wben && m_rd == idx) return alu_result;
        if (wb_valid && wb_rd == idx) return wb_val;
        return rf;
    endfunction

    always @(posedge clock) begin
        logic taken;
        if (reset) begin
            m_started = 1'b1;
            m_valid = 0; m_insn30 = 0; m_funct3 = 0; m_op1 = 0; m_op2 = 0; m_rd = 0; m_wben = 0;
        end else begin
            taken = in_valid && (!m_valid || out_ready);
            if (taken) begin
                m_op1    = (in_op1_sel == 2'd0) ? source_value(in_rs1, in_rs1_val)
                         : (in_op1_sel == 2'd1) ? in_pc : 32'd0;
                m_op2    = in_use_imm ? in_imm : source_value(in_rs2, in_rs2_val);
                m_insn30 = (in_funct3 == 3'd5 || (in_funct3 == 3'd0 && !in_use_imm)) ? in_insn30 : 1'b0;
                m_funct3 = in_funct3;
                m_rd     = in_rd;
                m_wben   = in_wben && in_rd != 0;
            end
            if (flush)      m_valid = 1'b0;
            else if (taken) m_valid = 1'b1;
            else if (out_ready) m_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_started) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            check("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
            if (m_valid) begin
                check("alu_op1", alu_op1, m_op1);
                check("alu_op2", alu_op2, m_op2);
                check("alu_insn30", {31'd0, alu_insn30}, {31'd0, m_insn30});
                check("alu_funct3", {29'd0, alu_funct3}, {29'd0, m_funct3});
                check("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
                check("out_wben", {31'd0, out_wben}, {31'd0, m_wben});
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [1:0] sel, input logic use_imm, input logic [2:0] f3,
                         input logic i30, input logic [4:0] rd, input logic wben);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = v1; in_rs2_val = v2;
        in_imm = imm; in_op1_sel = sel; in_use_imm = use_imm; in_funct3 = f3;
        in_insn30 = i30; in_rd = rd; in_wben = wben;
    endtask

    task automatic expect_held(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                               input logic i30, input logic [2:0] f3, input logic [4:0] rd,
                               input logic wben);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".op1"}, alu_op1, op1);
        check({tag, ".op2"}, alu_op2, op2);
        check({tag, ".insn30"}, {31'd0, alu_insn30}, {31'd0, i30});
        check({tag, ".funct3"}, {29'd0, alu_funct3}, {29'd0, f3});
        check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
        check({tag, ".wben"}, {31'd0, out_wben}, {31'd0, wben});
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".op1"}, alu_op1, 32'd0);
        check({tag, ".op2"}, alu_op2, 32'd0);
        check({tag, ".insn30"}, {31'd0, alu_insn30}, 32'd0);
        check({tag, ".funct3"}, {29'd0, alu_funct3}, 32'd0);
        check({tag, ".rd"}, {27'd0, out_rd}, 32'd0);
        check({tag, ".wben"}, {31'd0, out_wben}, 32'd0);
    endtask

    initial begin
        repeat (2) cyc();
        reset = 1'b0;
        expect_zero("reset");

        // add x3,x1,x2
        issue(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 2'd0, 1'b0, 3'd0, 1'b0, 5'd3, 1'b1);
        cyc();
        expect_held("add", 32'd5, 32'd7, 1'b0, 3'd0, 5'd3, 1'b1);

        // addi x4,x0,-1024 keeps insn30 low
        alu_result = 32'd12;
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FC00, 2'd0, 1'b1, 3'd0, 1'b1, 5'd4, 1'b1);
        cyc();
        expect_held("addi", 32'd0, 32'hFFFF_FC00, 1'b0, 3'd0, 5'd4, 1'b1);

        // srai x5,x6,3
        issue(5'd6, 5'd0, 32'h8000_0000, 32'd0, 32'd3, 2'd0, 1'b1, 3'd5, 1'b1, 5'd5, 1'b1);
        cyc();
        expect_held("srai", 32'h8000_0000, 32'd3, 1'b1, 3'd5, 5'd5, 1'b1);

        // addi x1,x0,9 then add x2,x1,x1 with stale regfile values
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'd9, 2'd0, 1'b1, 3'd0, 1'b0, 5'd1, 1'b1);
        cyc();
        alu_result = 32'd9;
        issue(5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 3'd0, 1'b0, 5'd2, 1'b1);
        cyc();
        expect_held("fwd_alu", 32'd9, 32'd9, 1'b0, 3'd0, 5'd2, 1'b1);

        // Same again with a competing writeback to x1
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'd9, 2'd0, 1'b1, 3'd0, 1'b0, 5'd1, 1'b1);
        cyc();
        wb_valid = 1'b1; wb_rd = 5'd1; wb_val = 32'd4;
        issue(5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 3'd0, 1'b0, 5'd2, 1'b1);
        cyc();
        expect_held("fwd_prio", 32'd9, 32'd9, 1'b0, 3'd0, 5'd2, 1'b1);

        // Writeback-only forward: held instruction writes a different register
        issue(5'd1, 5'd7, 32'd0, 32'd33, 32'd0, 2'd0, 1'b0, 3'd4, 1'b0, 5'd8, 1'b1);
        cyc();
        expect_held("fwd_wb", 32'd4, 32'd33, 1'b0, 3'd4, 5'd8, 1'b1);
        wb_valid = 1'b0;

        // Backpressure: held xor, pending or
        alu_result = 32'd0;
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'h55, 2'd0, 1'b1, 3'd4, 1'b0, 5'd9, 1'b1);
        cyc();
        out_ready = 1'b0;
        in_pc = 32'h100;
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'h66, 2'd1, 1'b1, 3'd6, 1'b0, 5'd10, 1'b1);
        #1 check("bp.in_ready", {31'd0, in_ready}, 32'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            cyc();
            check("bp.in_ready_hold", {31'd0, in_ready}, 32'd0);
            expect_held("bp.hold", 32'd0, 32'h55, 1'b0, 3'd4, 5'd9, 1'b1);
        end
        out_ready = 1'b1;
        #1 check("bp.release", {31'd0, in_ready}, 32'd1);
        cyc();
        expect_held("bp.next", 32'h100, 32'h66, 1'b0, 3'd6, 5'd10, 1'b1);
        in_valid = 1'b0;
        cyc();
        check("bp.drained", {31'd0, out_valid}, 32'd0);

        // Flush with a simultaneous accept
        issue(5'd0, 5'd0, 32'd0, 32'd0, 32'd1, 2'd2, 1'b1, 3'd0, 1'b0, 5'd11, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush.valid", {31'd0, out_valid}, 32'd0);

        // Reset while stalled
        cyc();
        out_ready = 1'b0; in_valid = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        expect_zero("stall_reset");

        // rd=0 never writes; rs1=0 ignores writeback to x0
        issue(5'd3, 5'd0, 32'd1, 32'd0, 32'd2, 2'd0, 1'b1, 3'd0, 1'b0, 5'd0, 1'b1);
        cyc();
        check("x0.wben", {31'd0, out_wben}, 32'd0);
        alu_result = 32'h1234_5678;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_val = 32'hDEAD_BEEF;
        issue(5'd0, 5'd0, 32'h7777_7777, 32'h7777_7777, 32'd0, 2'd0, 1'b0, 3'd0, 1'b0, 5'd12, 1'b1);
        cyc();
        expect_held("x0.src", 32'd0, 32'd0, 1'b0, 3'd0, 5'd12, 1'b1);

        // Random traffic with a narrow register range so hazards are common
        for (int unsigned n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_pc      = $urandom;
            in_rs1     = 5'($urandom_range(0, 3));
            in_rs2     = 5'($urandom_range(0, 3));
            in_rs1_val = $urandom;
            in_rs2_val = $urandom;
            in_imm     = $urandom;
            in_op1_sel = 2'($urandom_range(0, 3));
            in_use_imm = 1'($urandom_range(0, 1));
            in_funct3  = 3'($urandom_range(0, 7));
            in_insn30  = 1'($urandom_range(0, 1));
            in_rd      = 5'($urandom_range(0, 3));
            in_wben    = ($urandom_range(0, 3) != 0);
            alu_result = $urandom;
            wb_valid   = 1'($urandom_range(0, 1));
            wb_rd      = 5'($urandom_range(0, 3));
            wb_val     = $urandom;
            cyc();
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cyc();
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/yarvi_alu_issue.md
Name: yarvi_alu_issue

Overview:
- Operand-issue stage that sits directly upstream of the combinational yarvi_alu and feeds its insn30/funct3/op1/op2 inputs from registers.
- Accepts one decoded ALU instruction per cycle over a valid/ready handshake.
- Selects op1 (rs1/pc/zero) and op2 (rs2/imm), resolves RAW hazards by forwarding, and canonicalises insn30.
- Holds the issued instruction in an output register until the downstream (writeback) consumer accepts it.

Parameters:
- XLEN, 32, datapath width; only 32 is supported, since the shift amount is op2[4:0].
- FWD_EN, 1, 1 = forwarding from ALU result and writeback enabled; 0 = regfile values used unmodified.

Ports:
- clock  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard the held instruction and any instruction accepted this cycle
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction address
- in_rs1  in  5  source register 1 index
- in_rs2  in  5  source register 2 index
- in_rs1_val  in  XLEN  regfile read of rs1
- in_rs2_val  in  XLEN  regfile read of rs2
- in_imm  in  XLEN  sign-extended immediate
- in_op1_sel  in  2  0 = rs1, 1 = pc, 2 = zero, 3 = reserved (treated as zero)
- in_use_imm  in  1  op2 = imm instead of rs2
- in_funct3  in  3  ALU function (ADDSUB=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR_=5, OR=6, AND=7)
- in_insn30  in  1  raw instruction bit 30
- in_rd  in  5  destination index
- in_wben  in  1  instruction writes rd
- alu_result  in  XLEN  yarvi_alu result for the held instruction (combinational return)
- wb_valid  in  1  writeback stage is writing this cycle
- wb_rd  in  5  writeback destination
- wb_val  in  XLEN  writeback data
- out_valid  out  1  held instruction valid
- out_ready  in  1  downstream accepts the held instruction
- alu_insn30  out  1  to yarvi_alu
- alu_funct3  out  3  to yarvi_alu
- alu_op1  out  XLEN  to yarvi_alu
- alu_op2  out  XLEN  to yarvi_alu
- out_rd  out  5  destination of the held instruction
- out_wben  out  1  write enable of the held instruction

Behaviour:
- Reset: out_valid=0, alu_insn30=0, alu_funct3=0, alu_op1=0, alu_op2=0, out_rd=0, out_wben=0. Reset overrides flush and all handshakes.
- in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Accept occurs when in_valid && in_ready. The output register loads on the same edge, giving 1-cycle latency from accept to out_valid=1.
- Drain occurs when out_valid && out_ready with no accept; out_valid goes to 0 on that edge.
- If out_valid && !out_ready, every output register holds its value unchanged.
- flush: on the edge, out_valid=0 regardless of in_valid, out_ready or an accept in the same cycle. Data registers may update; they are don't-care while out_valid=0.
- Forwarding for rs1 and rs2, evaluated independently, first match wins:
  - (a) index==0 → value 0.
  - (b) out_valid && out_wben && out_rd==index → alu_result. This is the youngest source.
  - (c) wb_valid && wb_rd==index → wb_val.
  - (d) otherwise the regfile value.
  - With FWD_EN=0, only rules (a) and (d) apply.
- op1 = forwarded rs1, in_pc, or 0, per in_op1_sel. op2 = in_use_imm ? in_imm : forwarded rs2.
- insn30 canonicalisation:
  - alu_insn30 = in_insn30 if funct3==SR_, or if funct3==ADDSUB && !in_use_imm.
  - Otherwise alu_insn30 = 0. This forces ADDI with imm[10]=1 to add, not subtract, while SRAI is still honoured.
- out_wben is registered as in_wben && (in_rd!=0).
- No combinational path from in_* to out_*. alu_result feeds only the next operand mux; there is no loop, because alu_result depends only on registered outputs.

Test Plan:
- Reset, then in_valid=1 for "add x3,x1,x2" with rs1_val=5, rs2_val=7, insn30=0 → next cycle: out_valid=1, alu_op1=5, alu_op2=7, alu_insn30=0, alu_funct3=0, out_rd=3, out_wben=1.
- "addi x4,x0,-1024" (imm=0xFFFFFC00, insn30=1, funct3=0) → alu_insn30=0, alu_op1=0, alu_op2=0xFFFFFC00. "srai x5,x6,3" with insn30=1 → alu_insn30=1, alu_op2=3.
- Back-to-back: "addi x1,x0,9", then "add x2,x1,x1" with stale rs1_val=rs2_val=0, alu_result=9, out_ready=1 → second issue has alu_op1=alu_op2=9. Repeat with wb_valid=1, wb_rd=1, wb_val=4 present: ALU forward wins (9).
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 → in_ready=0 and outputs stable for all 3 cycles. out_ready=1 → input accepted on that edge, new values appear next cycle, nothing lost or duplicated.
- flush and an accept in the same cycle → out_valid=0 next cycle. Reset asserted while out_valid=1 && !out_ready → all outputs 0 next cycle.
- Writes to x0: rd=0 gives out_wben=0. A following instruction with rs1=0 gets op1=0 even with wb_valid=1, wb_rd=0, wb_val=0xDEADBEEF.
